ucode_dispatch: RTL and testbench
=================================

Name: ucode_dispatch

Overview:
- Consumer end of the front-end decode interface: accepts decoded micro-ops (microcode word plus raw 16-bit instruction and PC) from the decode stage over a valid/ready handshake.
- Buffers micro-ops in a small in-order FIFO.
- Dispatches the head micro-op to the functional unit named in its FU field.
- NOOP/invalid micro-ops are dropped at the head. Only one branch may be unresolved at a time. A flush empties the queue.

Parameters:
- DEPTH_P, 4, FIFO entries; power of two, ≥2.
- UCODE_WIDTH_P, package value, width of the microcode word.
- PC_WIDTH_P, 32, width of the instruction address.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- uop_v_i  in  1  decode has a micro-op
- uop_ready_o  out  1  queue can accept (not full)
- ucode_i  in  UCODE_WIDTH_P  microcode word {WE,OP,FU,FLAGS,DEST_SRC,S1_SRC,IMM_S2_SRC,IMM}
- instr_i  in  16  raw instruction
- pc_i  in  PC_WIDTH_P  instruction PC
- flush_i  in  1  discard all queued micro-ops
- fu_ready_i  in  NUM_FU  per-FU ready, one-hot index = FU code
- issue_v_o  out  NUM_FU  per-FU issue valid, at most one bit set
- issue_ucode_o  out  UCODE_WIDTH_P  head micro-op word
- issue_instr_o  out  16  head instruction
- issue_pc_o  out  PC_WIDTH_P  head PC
- br_resolved_i  in  1  backend resolved the outstanding branch
- empty_o  out  1  queue empty

Behaviour:
- Reset (async, reset_n_i low):
  - rd/wr pointers = 0, count = 0, state = IDLE.
  - uop_ready_o = 1, issue_v_o = 0, empty_o = 1.
  - issue_* data outputs = 0.
- Enqueue occurs when uop_v_i & uop_ready_o & !flush_i. uop_ready_o = (count != DEPTH_P); it is registered-count based, with no same-cycle pass-through of a dequeue.
- Outputs are combinational from the FIFO head; there is no bypass. Latency from enqueue to earliest issue is 1 cycle.
- FU field is extracted using package offsets:
  - head FU == NOOP_FU: entry is dequeued in that cycle with issue_v_o = 0 (drop, 1 cycle per NOOP).
  - Otherwise issue_v_o[FU] = !empty & (state == IDLE). Dequeue occurs when issue_v_o[FU] & fu_ready_i[FU].
- issue_v_o is held stable with unchanged data until accepted. Dropping it without acceptance is allowed only on flush.
- State machine:
  - IDLE → WAIT_BR on dequeue-issue of a BRANCH_FU micro-op.
  - WAIT_BR: no dispatch and no NOOP drop; enqueue continues.
  - WAIT_BR → IDLE on br_resolved_i or flush_i.
  - br_resolved_i in IDLE is ignored.
- flush_i (highest priority):
  - Next cycle count = 0, pointers = 0, state = IDLE.
  - A same-cycle enqueue is discarded.
  - A same-cycle handshake (issue_v_o & fu_ready_i) still counts as issued.
- Simultaneous enqueue and dequeue while full is impossible, because ready = 0 when full. When not full, count is unchanged and both pointers advance.
- Pointers are log2(DEPTH_P) bits and wrap naturally. count is log2(DEPTH_P)+1 bits.
- Reset mid-operation clears all state immediately. Queued micro-ops are lost.

Decomposition:
- Shared package, additions:
  - FU codes (NOOP_FU, ALU_FU, MUL_FU, DIV_FU, LOGICAL_FU, MEM_FU, BRANCH_FU) and NUM_FU.
  - Bit offsets/widths of every microcode field, and a ucode_t packed struct matching the ROM output order.
  - dispatch_state_e {IDLE, WAIT_BR}.
- One sub-module: uop_fifo. It is a parameterised synchronous FIFO with count, full/empty, and a flush clear.
- Dispatch, drop and branch FSM stay in ucode_dispatch.

Test Plan:
- Reset, then enqueue one ALU_FU micro-op (pc=0x100) with fu_ready_i[ALU] = 1 → next cycle issue_v_o[ALU] = 1, issue_pc_o = 0x100, then empty_o = 1.
- Enqueue 4 micro-ops with all fu_ready_i = 0 → uop_ready_o = 0 after the 4th. Raise ALU ready → one dequeue per cycle in order; uop_ready_o = 1 after the first dequeue.
- Enqueue NOOP, NOOP, MEM (pc=0x10, 0x12, 0x14), MEM ready → two idle drop cycles, then issue_v_o[MEM] = 1 with pc = 0x14.
- Enqueue BRANCH then ALU, all ready → branch issues. ALU is held with issue_v_o = 0 for 3 cycles until br_resolved_i pulses, then ALU issues the next cycle.
- Fill 3 entries, assert flush_i together with uop_v_i → next cycle empty_o = 1, issue_v_o = 0, and the flushed-cycle micro-op is absent.
- Deassert reset_n_i asynchronously mid-stream with 2 entries queued and state WAIT_BR → outputs go to reset values immediately; after release, the queue is empty and in IDLE.

Source files
------------

// File: rtl/ucode_dispatch_pkg.sv
// Shared definitions for the micro-op dispatch block: microcode field layout,
// functional-unit codes and dispatch FSM states.
package ucode_dispatch_pkg;

    localparam int WE_W         = 1;
    localparam int OP_W         = 4;
    localparam int FU_W         = 3;
    localparam int FLAGS_W      = 4;
    localparam int DEST_SRC_W   = 2;
    localparam int S1_SRC_W     = 2;
    localparam int IMM_S2_SRC_W = 2;
    localparam int IMM_W        = 16;

    // Fields packed MSB-first in ROM output order {WE,OP,FU,FLAGS,DEST_SRC,S1_SRC,IMM_S2_SRC,IMM}.
    localparam int IMM_LSB        = 0;
    localparam int IMM_S2_SRC_LSB = IMM_LSB + IMM_W;
    localparam int S1_SRC_LSB     = IMM_S2_SRC_LSB + IMM_S2_SRC_W;
    localparam int DEST_SRC_LSB   = S1_SRC_LSB + S1_SRC_W;
    localparam int FLAGS_LSB      = DEST_SRC_LSB + DEST_SRC_W;
    localparam int FU_LSB         = FLAGS_LSB + FLAGS_W;
    localparam int OP_LSB         = FU_LSB + FU_W;
    localparam int WE_LSB         = OP_LSB + OP_W;
    localparam int UCODE_WIDTH    = WE_LSB + WE_W;

    typedef enum logic [FU_W-1:0] {
        NOOP_FU    = 3'd0,
        ALU_FU     = 3'd1,
        MUL_FU     = 3'd2,
        DIV_FU     = 3'd3,
        LOGICAL_FU = 3'd4,
        MEM_FU     = 3'd5,
        BRANCH_FU  = 3'd6
    } fu_e;

    localparam int NUM_FU = 7;

    typedef struct packed {
        logic [WE_W-1:0]         we;
        logic [OP_W-1:0]         op;
        logic [FU_W-1:0]         fu;
        logic [FLAGS_W-1:0]      flags;
        logic [DEST_SRC_W-1:0]   dest_src;
        logic [S1_SRC_W-1:0]     s1_src;
        logic [IMM_S2_SRC_W-1:0] imm_s2_src;
        logic [IMM_W-1:0]        imm;
    } ucode_t;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_BR = 1'b1
    } dispatch_state_e;

    // NOOP and out-of-range codes have no unit to go to; they are dropped.
    function automatic logic fu_dispatchable(input logic [FU_W-1:0] fu);
        return (fu != NOOP_FU) && (fu < FU_W'(NUM_FU));
    endfunction

endpackage

// File: rtl/ucode_dispatch_fifo.sv
// In-order micro-op queue: power-of-two depth, occupancy count, and a
// synchronous flush that clears pointers and count.
module uop_fifo #(
    parameter int DEPTH_P = 4,
    parameter int WIDTH_P = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH_P-1:0]         wdata_i,
    output logic [WIDTH_P-1:0]         rdata_o,
    output logic [$clog2(DEPTH_P):0]   count_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH_P);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH_P-1:0] mem_q [DEPTH_P];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full, empty, do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH_P));
    assign empty   = (count_q == '0);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read after it was written, and the empty flag masks stale data.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = empty;

endmodule

// File: rtl/ucode_dispatch.sv
// Decode-side consumer: queues micro-ops, drops NOOPs at the head, issues the
// head to its functional unit, and stalls dispatch while a branch is unresolved.
module ucode_dispatch
    import ucode_dispatch_pkg::*;
#(
    parameter int DEPTH_P       = 4,
    parameter int UCODE_WIDTH_P = UCODE_WIDTH,
    parameter int PC_WIDTH_P    = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     uop_v_i,
    output logic                     uop_ready_o,
    input  logic [UCODE_WIDTH_P-1:0] ucode_i,
    input  logic [15:0]              instr_i,
    input  logic [PC_WIDTH_P-1:0]    pc_i,
    input  logic                     flush_i,
    input  logic [NUM_FU-1:0]        fu_ready_i,
    output logic [NUM_FU-1:0]        issue_v_o,
    output logic [UCODE_WIDTH_P-1:0] issue_ucode_o,
    output logic [15:0]              issue_instr_o,
    output logic [PC_WIDTH_P-1:0]    issue_pc_o,
    input  logic                     br_resolved_i,
    output logic                     empty_o
);

    localparam int ENTRY_W = UCODE_WIDTH_P + 16 + PC_WIDTH_P;
    localparam int CNT_W   = $clog2(DEPTH_P) + 1;

    dispatch_state_e          state_q, state_d;
    logic [ENTRY_W-1:0]       head;
    logic [CNT_W-1:0]         count;
    logic                     empty;
    logic [UCODE_WIDTH_P-1:0] head_ucode;
    logic [15:0]              head_instr;
    logic [PC_WIDTH_P-1:0]    head_pc;
    logic [FU_W-1:0]          head_fu;
    logic                     can_dispatch, drop, fire, enq, deq;

    uop_fifo #(
        .DEPTH_P (DEPTH_P),
        .WIDTH_P (ENTRY_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .push_i    (enq),
        .pop_i     (deq),
        .wdata_i   ({ucode_i, instr_i, pc_i}),
        .rdata_o   (head),
        .count_o   (count),
        .empty_o   (empty)
    );

    assign {head_ucode, head_instr, head_pc} = head;
    assign head_fu = head_ucode[FU_LSB +: FU_W];

    // Ready comes from the registered count only; a same-cycle dequeue never frees a slot early.
    assign uop_ready_o = (count != CNT_W'(DEPTH_P));
    assign enq         = uop_v_i & uop_ready_o & ~flush_i;

    assign can_dispatch = ~empty & (state_q == IDLE);
    assign drop         = can_dispatch & ~fu_dispatchable(head_fu);

    always_comb begin
        issue_v_o = '0;
        for (int i = 1; i < NUM_FU; i++) begin
            issue_v_o[i] = can_dispatch && (head_fu == FU_W'(i));
        end
    end

    assign fire = |(issue_v_o & fu_ready_i);
    assign deq  = drop | fire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire && head_fu == BRANCH_FU) state_d = WAIT_BR;
            WAIT_BR: if (br_resolved_i)                state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    assign issue_ucode_o = empty ? '0 : head_ucode;
    assign issue_instr_o = empty ? '0 : head_instr;
    assign issue_pc_o    = empty ? '0 : head_pc;
    assign empty_o       = empty;

endmodule

// File: tb/tb_ucode_dispatch.sv
// Self-checking bench for ucode_dispatch: directed scenarios plus random traffic,
// all compared each cycle against a queue-based behavioural model.
module tb_ucode_dispatch;
    import ucode_dispatch_pkg::*;

    localparam int DEPTH = 4;
    localparam int PCW   = 32;

    logic                   clk = 1'b0;
    logic                   reset_n_i;
    logic                   uop_v_i;
    logic                   uop_ready_o;
    logic [UCODE_WIDTH-1:0] ucode_i;
    logic [15:0]            instr_i;
    logic [PCW-1:0]         pc_i;
    logic                   flush_i;
    logic [NUM_FU-1:0]      fu_ready_i;
    logic [NUM_FU-1:0]      issue_v_o;
    logic [UCODE_WIDTH-1:0] issue_ucode_o;
    logic [15:0]            issue_instr_o;
    logic [PCW-1:0]         issue_pc_o;
    logic                   br_resolved_i;
    logic                   empty_o;

    always #5 clk = ~clk;

    ucode_dispatch #(
        .DEPTH_P       (DEPTH),
        .UCODE_WIDTH_P (UCODE_WIDTH),
        .PC_WIDTH_P    (PCW)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .uop_v_i       (uop_v_i),
        .uop_ready_o   (uop_ready_o),
        .ucode_i       (ucode_i),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .fu_ready_i    (fu_ready_i),
        .issue_v_o     (issue_v_o),
        .issue_ucode_o (issue_ucode_o),
        .issue_instr_o (issue_instr_o),
        .issue_pc_o    (issue_pc_o),
        .br_resolved_i (br_resolved_i),
        .empty_o       (empty_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: a plain queue of pending micro-ops plus a branch-outstanding flag.
    typedef struct packed {
        ucode_t         u;
        logic [15:0]    instr;
        logic [PCW-1:0] pc;
    } ent_t;

    ent_t              mq[$];
    bit                m_wait;
    logic [NUM_FU-1:0] m_v;
    bit                m_drop;

    function automatic ucode_t mk_uop(input int fu);
        logic [63:0] r;
        ucode_t      u;
        r    = {$urandom, $urandom};
        u    = r[UCODE_WIDTH-1:0];
        u.fu = fu[FU_W-1:0];
        return u;
    endfunction

    function automatic logic [NUM_FU-1:0] rmask(input int fu);
        logic [NUM_FU-1:0] m;
        m     = '0;
        m[fu] = 1'b1;
        return m;
    endfunction

    task automatic model_expect();
        int f;
        m_v    = '0;
        m_drop = 0;
        if (mq.size() > 0 && !m_wait) begin
            f = int'(mq[0].u.fu);
            if (f >= 1 && f < NUM_FU) m_v[f] = 1'b1;
            else                      m_drop = 1;
        end
        check("uop_ready", uop_ready_o, mq.size() < DEPTH);
        check("empty", empty_o, mq.size() == 0);
        check("issue_v", issue_v_o, m_v);
        if (mq.size() > 0) begin
            check("issue_ucode", issue_ucode_o, mq[0].u);
            check("issue_instr", issue_instr_o, mq[0].instr);
            check("issue_pc", issue_pc_o, mq[0].pc);
        end
    endtask

    task automatic model_commit();
        bit   fire;
        bit   enq;
        ent_t e;
        fire = |(m_v & fu_ready_i);
        enq  = uop_v_i && (mq.size() < DEPTH) && !flush_i;
        e    = {ucode_i, instr_i, pc_i};
        if (fire || m_drop) begin
            if (fire && mq[0].u.fu == BRANCH_FU) m_wait = 1;
            void'(mq.pop_front());
        end else if (m_wait && br_resolved_i) begin
            m_wait = 0;
        end
        if (flush_i) begin
            mq.delete();
            m_wait = 0;
        end else if (enq) begin
            mq.push_back(e);
        end
    endtask

    // One clock: drive inputs, check against the model at the falling edge, commit at the rising edge.
    task automatic step(input logic v, input ucode_t u, input logic [PCW-1:0] pc,
                        input logic fl, input logic [NUM_FU-1:0] rdy, input logic br);
        uop_v_i       = v;
        ucode_i       = u;
        instr_i       = 16'($urandom);
        pc_i          = pc;
        flush_i       = fl;
        fu_ready_i    = rdy;
        br_resolved_i = br;
        @(negedge clk);
        model_expect();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle(input logic [NUM_FU-1:0] rdy, input logic br);
        step(1'b0, mk_uop(int'(ALU_FU)), '0, 1'b0, rdy, br);
    endtask

    initial begin
        logic [NUM_FU-1:0] all_rdy;
        all_rdy       = '1;
        reset_n_i     = 1'b0;
        uop_v_i       = 1'b0;
        ucode_i       = '0;
        instr_i       = '0;
        pc_i          = '0;
        flush_i       = 1'b0;
        fu_ready_i    = '0;
        br_resolved_i = 1'b0;
        m_wait        = 0;
        #1;
        check("rst_ready", uop_ready_o, 1);
        check("rst_issue_v", issue_v_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_pc", issue_pc_o, 0);
        check("rst_ucode", issue_ucode_o, 0);
        repeat (2) @(posedge clk);
        #1 reset_n_i = 1'b1;

        // Single ALU op: issues the cycle after enqueue.
        step(1'b1, mk_uop(int'(ALU_FU)), 32'h100, 1'b0, rmask(int'(ALU_FU)), 1'b0);
        check("t1_issue_v", issue_v_o, rmask(int'(ALU_FU)));
        check("t1_pc", issue_pc_o, 32'h100);
        idle(rmask(int'(ALU_FU)), 1'b0);
        check("t1_empty", empty_o, 1);

        // Fill to capacity, then drain in order.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, mk_uop(int'(ALU_FU)), 32'h200 + 2 * i, 1'b0, '0, 1'b0);
        check("t2_full_ready", uop_ready_o, 0);
        idle(rmask(int'(ALU_FU)), 1'b0);
        check("t2_ready_after_deq", uop_ready_o, 1);
        for (int i = 1; i < DEPTH; i++) idle(rmask(int'(ALU_FU)), 1'b0);
        check("t2_drained", empty_o, 1);

        // Two NOOPs are dropped one per cycle ahead of a MEM op.
        step(1'b1, mk_uop(int'(NOOP_FU)), 32'h10, 1'b0, rmask(int'(MEM_FU)), 1'b0);
        step(1'b1, mk_uop(int'(NOOP_FU)), 32'h12, 1'b0, rmask(int'(MEM_FU)), 1'b0);
        step(1'b1, mk_uop(int'(MEM_FU)), 32'h14, 1'b0, rmask(int'(MEM_FU)), 1'b0);
        check("t3_issue_v", issue_v_o, rmask(int'(MEM_FU)));
        check("t3_pc", issue_pc_o, 32'h14);
        idle(rmask(int'(MEM_FU)), 1'b0);

        // Branch blocks the following ALU op until resolved.
        step(1'b1, mk_uop(int'(BRANCH_FU)), 32'h300, 1'b0, all_rdy, 1'b0);
        step(1'b1, mk_uop(int'(ALU_FU)), 32'h302, 1'b0, all_rdy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t4_hold", issue_v_o, 0);
            idle(all_rdy, 1'b0);
        end
        idle(all_rdy, 1'b1);
        check("t4_release", issue_v_o, rmask(int'(ALU_FU)));
        check("t4_pc", issue_pc_o, 32'h302);
        idle(all_rdy, 1'b0);

        // Flush with a simultaneous enqueue: the queue ends empty.
        for (int i = 0; i < 3; i++)
            step(1'b1, mk_uop(int'(MUL_FU)), 32'h400 + 2 * i, 1'b0, '0, 1'b0);
        step(1'b1, mk_uop(int'(DIV_FU)), 32'hDEAD, 1'b1, '0, 1'b0);
        check("t5_empty", empty_o, 1);
        check("t5_issue_v", issue_v_o, 0);
        idle('0, 1'b0);

        // Asynchronous reset while waiting on a branch with two entries queued.
        step(1'b1, mk_uop(int'(BRANCH_FU)), 32'h500, 1'b0, all_rdy, 1'b0);
        step(1'b1, mk_uop(int'(ALU_FU)), 32'h502, 1'b0, all_rdy, 1'b0);
        step(1'b1, mk_uop(int'(ALU_FU)), 32'h504, 1'b0, all_rdy, 1'b0);
        uop_v_i = 1'b0;
        check("t6_pre_empty", empty_o, 0);
        #2 reset_n_i = 1'b0;
        #1;
        check("t6_rst_ready", uop_ready_o, 1);
        check("t6_rst_issue_v", issue_v_o, 0);
        check("t6_rst_empty", empty_o, 1);
        check("t6_rst_pc", issue_pc_o, 0);
        check("t6_rst_instr", issue_instr_o, 0);
        mq.delete();
        m_wait = 0;
        @(posedge clk);
        #3 reset_n_i = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, mk_uop(int'(LOGICAL_FU)), 32'h600, 1'b0, all_rdy, 1'b0);
        check("t6_idle_issue", issue_v_o, rmask(int'(LOGICAL_FU)));
        idle(all_rdy, 1'b0);

        // Random traffic, including invalid FU codes, flushes and stray resolves.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 4) != 0,
                 mk_uop(int'($urandom % 8)),
                 $urandom,
                 ($urandom % 25) == 0,
                 NUM_FU'($urandom),
                 ($urandom % 4) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
